fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 98 +++++++++
 tb/tb_fetch_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Decoupling FIFO between the IF and ID stages: buffers up to DEPTH fetch packets,
// flushes on an EX redirect, and registers its ready/valid decodes with no bypass.
package fetch_buffer_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
      logic [31:0] pc_plus4;
      logic        valid_if_id;
   } if_id_reg_t;
endpackage

module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  if_id_reg_t                 in_entry,
   input  logic                       in_valid,
   output logic                       in_ready,
   output if_id_reg_t                 out_entry,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if_id_reg_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             push_c;
   logic             pop_c;

   // Handshake decodes come from registered occupancy only; out_ready never reaches in_ready.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != CNT_W'(0));
   assign count     = count_q;

   assign push_c = in_valid & in_ready & ~flush;
   assign pop_c  = out_valid & out_ready & ~flush;

   // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately unreset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   always_comb begin
      out_entry = '0;
      if (out_valid) begin
         out_entry             = mem_q[rd_ptr_q];
         out_entry.valid_if_id = 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a queue scoreboard predicts occupancy and the
// head packet, and every cycle's outputs are checked with immediate assertions.
module tb_fetch_buffer;
   import fetch_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst_n;
   if_id_reg_t       in_entry;
   logic             in_valid;
   logic             in_ready;
   if_id_reg_t       out_entry;
   logic             out_valid;
   logic             out_ready;
   logic             flush;
   logic [CNT_W-1:0] count;

   int         n_checks;
   int         n_fails;
   if_id_reg_t sb_q[$];

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_entry  (in_entry),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_entry (out_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic if_id_reg_t mk(input logic [31:0] pc);
      if_id_reg_t e;
      e.pc          = pc;
      e.instruction = pc ^ 32'hA5A5_0013;
      e.pc_plus4    = pc + 32'd4;
      e.valid_if_id = 1'b1;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the scoreboard's view of the current state.
   task automatic check_state(input string tag);
      int unsigned occ;
      if_id_reg_t  exp_e;
      occ = sb_q.size();
      chk({tag, ".count"}, 128'(count), 128'(occ));
      chk({tag, ".in_ready"}, 128'(in_ready), 128'(occ != DEPTH));
      chk({tag, ".out_valid"}, 128'(out_valid), 128'(occ != 0));
      exp_e = '0;
      if (occ != 0) exp_e = sb_q[0];
      chk({tag, ".out_entry"}, 128'(out_entry), 128'(exp_e));
   endtask

   // Check outputs, drive one cycle of stimulus, then update the scoreboard.
   task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                       input logic ordy, input logic fl);
      logic do_push;
      logic do_pop;
      check_state(tag);
      do_push   = iv && (sb_q.size() != DEPTH) && !fl;
      do_pop    = ordy && (sb_q.size() != 0) && !fl;
      in_valid  = iv;
      in_entry  = mk(pc);
      in_entry.valid_if_id = iv;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      if (fl) sb_q.delete();
      else begin
         if (do_pop) void'(sb_q.pop_front());
         if (do_push) sb_q.push_back(mk(pc));
      end
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      in_valid  = 1'b0;
      in_entry  = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      rst_n = 1'b1;

      // Fill to DEPTH with ID stalled, then offer a fifth packet that must bounce.
      for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
      chk("full.head_pc", 128'(out_entry.pc), 128'(32'h0));
      step("full_offer", 1'b1, 32'h10, 1'b0, 1'b0);

      // Drain in order with no new fetches.
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 32'h0, 1'b1, 1'b0);
      chk("drained.out_valid", 128'(out_valid), 128'(1'b0));

      // Single push into an empty buffer: visible only from the next cycle.
      in_valid = 1'b1;
      in_entry = mk(32'h100);
      #1;
      chk("nobypass.out_valid", 128'(out_valid), 128'(1'b0));
      step("latency_push", 1'b1, 32'h100, 1'b0, 1'b0);
      chk("latency.pc", 128'(out_entry.pc), 128'(32'h100));
      step("latency_pop", 1'b0, 32'h0, 1'b1, 1'b0);

      // Steady state at count=2 with simultaneous push/pop, wrapping the pointers.
      step("ss_pre", 1'b1, 32'h200, 1'b0, 1'b0);
      step("ss_pre", 1'b1, 32'h204, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step("steady", 1'b1, 32'(32'h208 + i * 4), 1'b1, 1'b0);
      chk("steady.count", 128'(count), 128'(2));
      step("ss_drain", 1'b0, 32'h0, 1'b1, 1'b0);
      step("ss_drain", 1'b0, 32'h0, 1'b1, 1'b0);

      // Flush at count=3 overrides same-cycle push and pop.
      for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 32'(32'h300 + i * 4), 1'b0, 1'b0);
      step("flush", 1'b1, 32'h3F0, 1'b1, 1'b1);
      chk("post_flush.count", 128'(count), 128'(0));
      step("post_flush", 1'b1, 32'h400, 1'b0, 1'b0);
      step("post_flush_pop", 1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges with two packets held.
      step("pre_rst", 1'b1, 32'h500, 1'b0, 1'b0);
      step("pre_rst", 1'b1, 32'h504, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_state("async_rst");
      #2;
      rst_n = 1'b1;
      step("after_rst", 1'b1, 32'h600, 1'b0, 1'b0);
      step("after_rst_pop", 1'b0, 32'h0, 1'b1, 1'b0);
      check_state("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
